// File: rtl/dmem_access.sv
// dmem_access: load/store unit between the execute stage and a req/gnt/rvalid
// data-memory port. Captures one access, drives a word-aligned request with
// byte enables, extracts and extends load data, and stalls upstream meanwhile.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (trap misaligned H/W accesses
// instead of issuing them with the low offending address bits ignored).
module dmem_access #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_i,
   input  logic [AWIDTH-1:0] addr_i,
   input  logic [DWIDTH-1:0] store_data_i,
   input  logic              memren_i,
   input  logic              memwen_i,
   input  logic [2:0]        funct3_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_wdata_o,
   output logic [3:0]        mem_be_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DWIDTH-1:0] mem_rdata_i,
   output logic [DWIDTH-1:0] memory_data_o,
   output logic              stall_o,
   output logic              done_o,
   output logic              misaligned_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Undefined funct3 encodings fall through to word size.
   function automatic logic [1:0] size_of(input logic [2:0] f);
      case (f)
         3'b000, 3'b100: size_of = SZ_B;
         3'b001, 3'b101: size_of = SZ_H;
         default:        size_of = SZ_W;
      endcase
   endfunction

   // Byte lane offset; bits that would make an H/W access misaligned are dropped.
   function automatic logic [1:0] lane_off(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         SZ_B:    lane_off = a;
         SZ_H:    lane_off = {a[1], 1'b0};
         default: lane_off = 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         SZ_B:    lane_be = 4'b0001 << off;
         SZ_H:    lane_be = 4'b0011 << off;
         default: lane_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [DWIDTH-1:0] store_lanes(input logic [1:0] sz,
                                                     input logic [DWIDTH-1:0] d);
      case (sz)
         SZ_B:    store_lanes = {(DWIDTH/8){d[7:0]}};
         SZ_H:    store_lanes = {(DWIDTH/16){d[15:0]}};
         default: store_lanes = d;
      endcase
   endfunction

   // Shift the addressed lane down, then sign- or zero-extend (funct3[2] = unsigned).
   function automatic logic [DWIDTH-1:0] load_extract(input logic [DWIDTH-1:0] rdata,
                                                      input logic [2:0] f,
                                                      input logic [1:0] off);
      logic [DWIDTH-1:0] sh;
      logic              sgn;
      sh  = rdata >> {off, 3'b000};
      sgn = ~f[2];
      case (size_of(f))
         SZ_B:    load_extract = {{(DWIDTH-8){sh[7] & sgn}}, sh[7:0]};
         SZ_H:    load_extract = {{(DWIDTH-16){sh[15] & sgn}}, sh[15:0]};
         default: load_extract = sh;
      endcase
   endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
      is_misaligned = ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'b00));
   endfunction
`endif

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] sdata_q, sdata_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              we_q, we_d;
   logic [DWIDTH-1:0] mdata_q, mdata_d;
   logic              mis_q, mis_d;
   logic              accept;
   logic [1:0]        size_q;
   logic [1:0]        off_q;

   assign size_q = size_of(funct3_q);
   assign off_q  = lane_off(size_q, addr_q[1:0]);
   assign accept = (state_q == S_IDLE) && valid_i && (memren_i || memwen_i);

   // Next-state logic and access capture.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      sdata_d  = sdata_q;
      funct3_d = funct3_q;
      we_d     = we_q;
      mdata_d  = mdata_q;
      mis_d    = mis_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               addr_d   = addr_i;
               sdata_d  = store_data_i;
               funct3_d = funct3_i;
               we_d     = memwen_i;
               mis_d    = 1'b0;
               state_d  = S_REQ;
`ifdef DMEM_MISALIGN_TRAP_EN
               if (is_misaligned(size_of(funct3_i), addr_i[1:0])) begin
                  mis_d   = 1'b1;
                  state_d = S_DONE;
               end
`endif
            end
         end
         S_REQ: begin
            if (mem_gnt_i) state_d = we_q ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid_i) begin
               mdata_d = load_extract(mem_rdata_i, funct3_q, off_q);
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and capture registers; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         sdata_q  <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         mdata_q  <= '0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         sdata_q  <= sdata_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
         mdata_q  <= mdata_d;
         mis_q    <= mis_d;
      end
   end

   // Memory port and pipeline handshake outputs.
   always_comb begin
      mem_req_o     = (state_q == S_REQ);
      mem_we_o      = mem_req_o && we_q;
      mem_addr_o    = {addr_q[AWIDTH-1:2], 2'b00};
      mem_be_o      = mem_req_o ? lane_be(size_q, off_q) : 4'b0000;
      mem_wdata_o   = mem_we_o ? store_lanes(size_q, sdata_q) : '0;
      memory_data_o = mdata_q;
      stall_o       = (state_q == S_REQ) || (state_q == S_WAIT) || accept;
      done_o        = (state_q == S_DONE);
`ifdef DMEM_MISALIGN_TRAP_EN
      misaligned_o  = done_o && mis_q;
`else
      misaligned_o  = 1'b0 & mis_q;
`endif
   end

endmodule
